// File: rtl/adc_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : adc_frame_buffer
// Purpose  : Decimates one of eight 12-bit unsigned ADC channels to a fixed
//            sample rate, converts each sample to two's complement, collects
//            FRAME_LEN samples into a ping-pong buffer and streams complete
//            frames with valid/ready and start/end-of-packet markers.
// Ports    : CLOCK, RESET       - clock and synchronous active-high reset
//            ENABLE             - sampling enable (prescaler runs while high)
//            CH_SEL             - channel select, latched at each frame start
//            CH0..CH7           - unsigned ADC results, same clock domain
//            SRC_DATA/VALID/READY/SOP/EOP - frame stream towards the FFT
//            OVERRUN            - one-cycle pulse per dropped sample tick
// Revision : 1.0 - initial release
// ============================================================================
module adc_frame_buffer #(
  parameter int FRAME_LEN = 256,
  parameter int DIV       = 500
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [2:0]  CH_SEL,
  input  logic [11:0] CH0,
  input  logic [11:0] CH1,
  input  logic [11:0] CH2,
  input  logic [11:0] CH3,
  input  logic [11:0] CH4,
  input  logic [11:0] CH5,
  input  logic [11:0] CH6,
  input  logic [11:0] CH7,
  output logic [11:0] SRC_DATA,
  output logic        SRC_VALID,
  input  logic        SRC_READY,
  output logic        SRC_SOP,
  output logic        SRC_EOP,
  output logic        OVERRUN
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(DIV);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // --------------------------------------------------------------------------
  // Prescaler
  // --------------------------------------------------------------------------
  logic [CW-1:0] presc_cnt;
  logic          tick;

  assign tick = ENABLE && (presc_cnt == CNT_MAX);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      presc_cnt <= '0;
    end else if (!ENABLE) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Writer state
  // --------------------------------------------------------------------------
  logic [1:0]    full;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          wr_wait;
  logic [2:0]    ch_lat;

  logic          other_full;
  logic          tgt_bank;
  logic          do_write;
  logic          drop;
  logic          last_write;
  logic [2:0]    active_sel;
  logic [11:0]   raw;
  logic [11:0]   sample;

  assign other_full = full[~wr_bank];

  // While waiting, the bank being waited for is the one that becomes writable
  // as soon as its full flag clears; the tick on that cycle lands at address 0.
  assign tgt_bank   = wr_wait ? ~wr_bank : wr_bank;
  assign do_write   = tick && (!wr_wait || !other_full);
  assign drop       = tick && wr_wait && other_full;
  assign last_write = do_write && (wr_addr == LAST_ADDR);

  // A write to address 0 uses the live select so the new frame picks up the
  // current channel; later writes in the frame use the latched copy.
  assign active_sel = (wr_addr == '0) ? CH_SEL : ch_lat;

  always_comb begin
    raw = CH0;
    case (active_sel)
      3'd0:    raw = CH0;
      3'd1:    raw = CH1;
      3'd2:    raw = CH2;
      3'd3:    raw = CH3;
      3'd4:    raw = CH4;
      3'd5:    raw = CH5;
      3'd6:    raw = CH6;
      default: raw = CH7;
    endcase
  end

  // Offset-binary to two's complement: flipping the MSB subtracts 2048.
  assign sample = {~raw[11], raw[10:0]};

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
      wr_wait <= 1'b0;
      ch_lat  <= 3'd0;
      OVERRUN <= 1'b0;
    end else begin
      OVERRUN <= drop;
      // Leave WAIT the first cycle the other bank is seen released.
      if (wr_wait && !other_full) begin
        wr_wait <= 1'b0;
        wr_bank <= ~wr_bank;
      end
      if (do_write) begin
        if (wr_addr == '0) begin
          ch_lat <= CH_SEL;
        end
        if (wr_addr == LAST_ADDR) begin
          wr_addr <= '0;
          // FRAME_LEN >= 4, so a last write never coincides with a WAIT exit
          // and tgt_bank equals wr_bank here.
          if (other_full) begin
            wr_wait <= 1'b1;
          end else begin
            wr_bank <= ~wr_bank;
          end
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sample storage: both banks in one array, bank select is the address MSB.
  // --------------------------------------------------------------------------
  logic [11:0] mem [0:2*FRAME_LEN-1];

  always_ff @(posedge CLOCK) begin
    if (do_write) begin
      mem[{tgt_bank, wr_addr}] <= sample;
    end
  end

  // --------------------------------------------------------------------------
  // Reader
  // --------------------------------------------------------------------------
  logic [0:0]    rd_state;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_next;
  logic          xfer;
  logic          rd_release;
  logic          rd_en;
  logic [AW:0]   rd_ptr;

  assign xfer       = SRC_VALID && SRC_READY;
  assign rd_next    = rd_addr + 1'b1;
  assign rd_release = (rd_state == ST_STREAM) && xfer && SRC_EOP;

  // SRC_DATA is the registered RAM read port and doubles as the prefetch
  // register: it only reloads when its current word is consumed (or when a
  // frame starts), so the word is held stable under backpressure and the
  // next word is ready the cycle after each transfer.
  always_comb begin
    rd_en  = 1'b0;
    rd_ptr = {rd_bank, rd_addr};
    if ((rd_state == ST_IDLE) && full[rd_bank]) begin
      rd_en  = 1'b1;
      rd_ptr = {rd_bank, {AW{1'b0}}};
    end else if ((rd_state == ST_STREAM) && xfer && !SRC_EOP) begin
      rd_en  = 1'b1;
      rd_ptr = {rd_bank, rd_next};
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      SRC_DATA <= 12'd0;
    end else if (rd_en) begin
      SRC_DATA <= mem[rd_ptr];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_state  <= ST_IDLE;
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      SRC_VALID <= 1'b0;
      SRC_SOP   <= 1'b0;
      SRC_EOP   <= 1'b0;
    end else begin
      case (rd_state)
        ST_IDLE: begin
          if (full[rd_bank]) begin
            rd_state  <= ST_STREAM;
            rd_addr   <= '0;
            SRC_VALID <= 1'b1;
            SRC_SOP   <= 1'b1;
            SRC_EOP   <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            if (SRC_EOP) begin
              rd_state  <= ST_IDLE;
              rd_bank   <= ~rd_bank;
              SRC_VALID <= 1'b0;
              SRC_SOP   <= 1'b0;
              SRC_EOP   <= 1'b0;
            end else begin
              rd_addr <= rd_next;
              SRC_SOP <= 1'b0;
              SRC_EOP <= (rd_next == LAST_ADDR);
            end
          end
        end
        default: begin
          rd_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Full flags: set by the writer's last write, cleared by the EOP transfer.
  // The two never target the same bank in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      full <= 2'b00;
    end else begin
      if (rd_release) begin
        full[rd_bank] <= 1'b0;
      end
      if (last_write) begin
        full[wr_bank] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_frame_buffer
// Purpose  : Self-checking bench for adc_frame_buffer (FRAME_LEN=8, DIV=4).
//            A cycle model of the prescaler and ping-pong occupancy pushes
//            expected samples into a queue on every tick; transfers pop and
//            compare data, SOP and EOP. Also checks OVERRUN pulses, output
//            stability under backpressure and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_frame_buffer;

  localparam int FL = 8;
  localparam int DV = 4;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic        SRC_READY = 1'b0;
  logic [2:0]  CH_SEL = 3'd2;
  logic [11:0] ch [8];
  logic [11:0] SRC_DATA;
  logic        SRC_VALID, SRC_SOP, SRC_EOP, OVERRUN;

  adc_frame_buffer #(.FRAME_LEN(FL), .DIV(DV)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .CH_SEL(CH_SEL),
    .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
    .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
    .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID), .SRC_READY(SRC_READY),
    .SRC_SOP(SRC_SOP), .SRC_EOP(SRC_EOP), .OVERRUN(OVERRUN)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [11:0] d;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Channel stimulus modes: 0 hold, 1 ramp on CH2, 2 random all, 3 corners.
  int          mode = 2;
  int          drv_prev = -1;
  int          drv_rv = 0;
  bit          tick_seen = 1'b0;
  logic [11:0] corners [4];

  initial begin
    corners[0] = 12'd0;
    corners[1] = 12'd2048;
    corners[2] = 12'd4095;
    corners[3] = 12'd2047;
    for (int i = 0; i < 8; i++) ch[i] = 12'd0;
    forever begin
      @(posedge CLOCK);
      #1;
      if (mode != drv_prev) drv_rv = 0;
      else if (tick_seen) drv_rv++;
      drv_prev = mode;
      case (mode)
        1: ch[2] = 12'(2048 + drv_rv);
        2: for (int i = 0; i < 8; i++) ch[i] = 12'($urandom_range(0, 4095));
        3: ch[2] = corners[drv_rv % 4];
        default: ;
      endcase
    end
  end

  // Reference model and scoreboard, evaluated mid-cycle.
  int         mcnt = 0, m_addr = 0, nf = 0, m_ch = 0;
  bit         m_wait = 1'b0, ov_pend = 1'b0, prev_stall = 1'b0;
  int         ov_model = 0, ov_seen = 0;
  logic [13:0] prev_out = '0;

  always @(negedge CLOCK) begin
    exp_t e;
    bit   tk, rel;
    tick_seen = 1'b0;
    if (RESET) begin
      mcnt = 0; m_addr = 0; nf = 0; m_ch = 0;
      m_wait = 1'b0; ov_pend = 1'b0; prev_stall = 1'b0;
      q.delete();
    end else begin
      if (OVERRUN || ov_pend) check("overrun", 32'(OVERRUN), 32'(ov_pend));
      if (OVERRUN) ov_seen++;
      ov_pend = 1'b0;
      if (prev_stall) begin
        check("hold_valid", 32'(SRC_VALID), 32'd1);
        check("hold_data", 32'({SRC_DATA, SRC_SOP, SRC_EOP}), 32'(prev_out));
      end
      rel = 1'b0;
      if (SRC_VALID && SRC_READY) begin
        if (q.size() == 0) begin
          check("spurious", 32'(SRC_VALID), 32'd0);
        end else begin
          e = q.pop_front();
          check("data", 32'(SRC_DATA), 32'(e.d));
          check("sop", 32'(SRC_SOP), 32'(e.sop));
          check("eop", 32'(SRC_EOP), 32'(e.eop));
          rel = e.eop;
        end
      end
      prev_stall = SRC_VALID && !SRC_READY;
      prev_out   = {SRC_DATA, SRC_SOP, SRC_EOP};
      tk = 1'b0;
      if (ENABLE) begin
        if (mcnt == DV - 1) begin tk = 1'b1; mcnt = 0; end
        else mcnt++;
      end else begin
        mcnt = 0;
      end
      if (tk) begin
        tick_seen = 1'b1;
        if (m_wait && nf == 2) begin
          ov_pend = 1'b1;
          ov_model++;
        end else begin
          m_wait = 1'b0;
          if (m_addr == 0) m_ch = int'(CH_SEL);
          e.d   = 12'(int'(ch[m_ch]) - 2048);
          e.sop = (m_addr == 0);
          e.eop = (m_addr == FL - 1);
          q.push_back(e);
          m_addr++;
          if (m_addr == FL) begin
            m_addr = 0;
            nf++;
            if (nf == 2) m_wait = 1'b1;
          end
        end
      end
      if (rel) nf--;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge CLOCK); #1; end
  endtask

  task automatic do_reset(input int n);
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    repeat (n) begin
      @(posedge CLOCK);
      @(negedge CLOCK);
      check("rst_valid", 32'(SRC_VALID), 32'd0);
      check("rst_outs", 32'({SRC_DATA, SRC_SOP, SRC_EOP, OVERRUN}), 32'd0);
    end
    @(posedge CLOCK); #1;
    RESET = 1'b0;
  endtask

  initial begin
    int base, k;
    // Power-up reset, then run with ENABLE high before the checked reset.
    cycles(2);
    RESET = 1'b0;
    ENABLE = 1'b1;
    cycles(6);
    do_reset(4);

    // Ramp on CH2 with the consumer always ready.
    base = ov_seen;
    mode = 1; CH_SEL = 3'd2; SRC_READY = 1'b1;
    cycles(FL * DV * 3 + 10);
    check("ramp_no_overrun", 32'(ov_seen - base), 32'd0);

    // Conversion corners.
    mode = 3;
    cycles(FL * DV * 2 + 10);

    // Random backpressure at ~30% ready with random channel data.
    mode = 2;
    for (int i = 0; i < 800; i++) begin
      SRC_READY = ($urandom_range(0, 9) < 3);
      cycles(1);
    end

    // Overrun: consumer stalled for three frame periods.
    base = ov_seen;
    SRC_READY = 1'b0;
    cycles(FL * DV * 3);
    check("overrun_seen", 32'(ov_seen - base > 0), 32'd1);
    SRC_READY = 1'b1;
    cycles(FL * DV * 3);

    // Channel select change at sample 3 of a frame.
    CH_SEL = 3'd2;
    k = 0;
    while (m_addr != 3 && k < 200) begin cycles(1); k++; end
    if (m_addr != 3) check("wait_addr", 32'(m_addr), 32'd3);
    CH_SEL = 3'd5;
    cycles(FL * DV * 2 + 10);

    // Reset in the middle of a stream.
    k = 0;
    while (!SRC_VALID && k < 200) begin cycles(1); k++; end
    if (!SRC_VALID) check("wait_valid", 32'(SRC_VALID), 32'd1);
    RESET = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    check("rst_drop", 32'(SRC_VALID), 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    cycles(FL * DV * 3 + 10);

    // Stop sampling and drain; only the partial frame may remain queued.
    ENABLE = 1'b0;
    cycles(40);
    check("drain_left", 32'(q.size()), 32'(m_addr));
    check("ov_count", 32'(ov_seen), 32'(ov_model));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_frame_buffer.md
# adc_frame_buffer

Downstream stage of the DE1 ADC controller. Takes its eight 12-bit channel outputs, decimates one selected channel to a fixed sample rate, and converts each sample to signed. Collects FRAME_LEN samples into a ping-pong buffer and streams complete frames with valid/ready and start/end markers to the FFT input.

## Interface
Parameters:
- FRAME_LEN, 256: samples per frame; a power of two, at least 4.
- DIV, 500: CLOCK cycles per sample tick (50 MHz / 500 = 100 kS/s); at least 2.

Ports:
- CLOCK  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  sampling enable.
- CH_SEL  in  3  channel select, 0..7.
- CH0..CH7  in  12 each  unsigned ADC results from the ADC controller, same clock domain.
- SRC_DATA  out  12  signed sample (two's complement).
- SRC_VALID  out  1  SRC_DATA/SOP/EOP valid.
- SRC_READY  in  1  consumer accepts; a transfer occurs on a cycle where SRC_VALID and SRC_READY are both high.
- SRC_SOP  out  1  first sample of a frame.
- SRC_EOP  out  1  last sample of a frame.
- OVERRUN  out  1  one-cycle pulse for each dropped sample tick.

## Operation
- **Prescaler:** counts 0..DIV-1 while ENABLE=1.
  - A tick occurs on the cycle the count equals DIV-1; the count then wraps to 0.
  - While ENABLE=0 the count holds at 0 and no ticks occur. A partial frame is retained and resumes when ENABLE returns high.
- **Channel selection:** CH_SEL is latched on the tick that writes address 0 of a frame. A CH_SEL change mid-frame takes effect at the next frame.
- **Conversion:** sample = {~CHn[11], CHn[10:0]}, which equals CHn - 2048. CHn is the value present on the tick cycle.
- **Storage:** two banks of FRAME_LEN x 12, with a full[1:0] flag per bank, a write bank/address, and a read bank.
- **Writer:**
  - On each tick, writes the sample to wr_addr of wr_bank and increments wr_addr.
  - After writing address FRAME_LEN-1, it sets full[wr_bank] and wraps wr_addr to 0.
  - It then needs bank ~wr_bank. If full[~wr_bank] is 0, it switches to that bank.
  - Otherwise it enters WAIT. In WAIT, each tick is dropped and pulses OVERRUN for one cycle. WAIT ends when the other bank is released, and writing continues at address 0 of that bank.
- **Reader FSM:** IDLE -> STREAM -> IDLE.
  - IDLE: when full[rd_bank]=1, enter STREAM.
  - STREAM: present addresses 0..FRAME_LEN-1 of rd_bank in order. SRC_SOP is high with address 0 and SRC_EOP with address FRAME_LEN-1.
  - On the EOP transfer: clear full[rd_bank], toggle rd_bank, and return to IDLE. If the other bank is already full, the next frame starts without waiting.
- **Frame order:** frames are delivered in capture order. Frames are never partial or reordered. Dropped samples only ever occur as whole-tick gaps while in WAIT.
- **Reset:**
  - Cleared to zero: prescaler, both full flags, wr_bank, wr_addr, rd_bank, and the FSM (to IDLE).
  - Output reset values: SRC_DATA=0, SRC_VALID=0, SRC_SOP=0, SRC_EOP=0, OVERRUN=0.
  - Bank contents need no reset. A reset mid-frame or mid-stream discards everything.

## Timing
- **Ticks:** a tick occurs every DIV cycles with ENABLE held high. The first tick after reset or after ENABLE rises comes DIV cycles later.
- **Latency:** the first SRC_VALID of a frame rises no later than 3 cycles after the tick that writes address FRAME_LEN-1.
- **Throughput:** one sample per cycle while SRC_READY=1, with no bubbles inside a frame.
- **Backpressure:** while SRC_VALID=1 and SRC_READY=0, SRC_DATA, SRC_SOP and SRC_EOP are held stable. SRC_VALID does not drop mid-frame.
- **Read pipeline:** RAM read latency is 1 cycle. A prefetch/skid register is required to meet the no-bubble and stability rules.
- **Release visibility:** a bank released by an EOP transfer in cycle t is usable by the writer from cycle t+1. A WAIT-state tick in cycle t is dropped.
- **Full-flag timing:** full[] is set in the cycle of the last write and is visible to the reader in the next cycle.
- **No-overrun condition:** with SRC_READY held high and FRAME_LEN+3 < FRAME_LEN*DIV, OVERRUN never pulses.

## Test plan
- **Reset:** hold RESET 5 cycles, with ENABLE=1 before and after. Outputs are all 0 during reset. The first tick comes DIV cycles after RESET falls.
- **Ramp:** FRAME_LEN=8, DIV=4, CH_SEL=2, CH2 incremented by 1 every tick starting at 2048, SRC_READY=1. Frame 0..7 arrives with SOP on 0 and EOP on 7, then the next frame 8..15, with no OVERRUN.
- **Conversion corners:** CH=0, 2048, 4095, 2047 produce SRC_DATA 0x800, 0x000, 0x7FF, 0xFFF respectively.
- **Random backpressure:** random SRC_READY at 30% high. The scoreboard sees every sample in order, data is stable while stalled, and SOP/EOP fall on the correct indices.
- **Overrun:** SRC_READY=0 for 3 frame periods (FRAME_LEN=8, DIV=4). Two frames are stored and each later tick pulses OVERRUN. After SRC_READY=1, frame A then frame B are delivered, and capture resumes at address 0 of the released bank.
- **CH_SEL and reset:** CH_SEL changes 2->5 at sample 3 and takes effect only at the next frame's sample 0. RESET asserted mid-stream drops SRC_VALID to 0 the next cycle, and no stale frame appears afterwards.
